alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
//
// PURPOSE
//   Iterative RV32M multiply/divide unit. It sits beside the single-cycle
//   integer ALU in the EX stage.
//   It takes operands a/b and a 3-bit funct3 op code through a valid/ready
//   handshake, then computes for WIDTH cycles: a radix-2 shift-add
//   multiplier and a restoring divider.
//   It holds the result until the pipeline consumes it, and can be killed
//   by a pipeline flush.
//
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be >= 4
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      synchronous active-low reset
//   flush      in   1      kill in-flight or held operation
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request this cycle
//   op         in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                          100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b       in   WIDTH  operands (rs1, rs2)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  selected result
//   zero       out  1      result == 0 (same meaning as the ALU zero flag)
//   busy       out  1      state != IDLE
//
// BEHAVIOUR
//   - Reset: when rst_n=0 at an edge, go to IDLE and clear all outputs.
//     in_ready returns 1 from the next cycle.
//   - Reset wins over every other input.
//   - States: IDLE, CALC, DONE.
//     in_ready = (IDLE) | (DONE & out_ready).
//     out_valid = DONE.
//   - Accept: in_valid & in_ready & ~flush at an edge. At that edge,
//     latch op, the sign flags and the absolute-value operands, and clear
//     the counter.
//     Signed: MULH (a and b), MULHSU (a only), DIV and REM (a and b).
//   - Accept in IDLE or DONE:
//     - special case -> DONE
//     - otherwise -> CALC
//   - Special cases (divide ops only; these skip CALC):
//     - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//     - Signed overflow (DIV/REM with a = 1<<(WIDTH-1) and b = all ones):
//       DIV -> a; REM -> 0.
//   - CALC runs exactly WIDTH iterations, one per edge.
//     After the WIDTH-th iteration: apply the sign fixup and go to DONE.
//   - Multiply: 2*WIDTH-bit unsigned product of magnitudes, negated when
//     the operand signs differ.
//     MUL -> low WIDTH bits; MULH, MULHSU and MULHU -> high WIDTH bits.
//   - Divide: unsigned quotient and remainder of magnitudes.
//     - Quotient is negated when the signs differ.
//     - Remainder takes the sign of a.
//   - Latency, counted from the accepting edge:
//     - normal op: out_valid = 1 after WIDTH+1 edges
//     - special case: out_valid = 1 after 1 edge
//   - DONE: result and zero stay stable until out_valid & out_ready at an
//     edge.
//     - If in_valid is also high at that edge, accept the new request
//       (back-to-back).
//     - Otherwise go to IDLE.
//   - flush=1 at an edge: go to IDLE and force out_valid=0; no accept
//     happens that cycle.
//     in_ready is combinationally 0 while flush=1, and flush beats
//     in_valid.
//   - result and zero hold their last value in IDLE and CALC; they are
//     defined only while out_valid=1.
//   - Internal widths: product accumulator 2*WIDTH bits; remainder WIDTH+1
//     bits.
//     Subtraction is the a - b form of the ALU sub path, carried out on
//     magnitudes.
//
// TESTING (WIDTH=32)
//   1. MUL a=7, b=-3 -> result 0xFFFFFFEB.
//      MULH a=0x80000000, b=0x80000000 -> 0x40000000.
//      out_valid asserted exactly 33 edges after accept.
//   2. DIV a=-7, b=2 -> 0xFFFFFFFD.
//      REM a=-7, b=2 -> 0xFFFFFFFF.
//      DIVU a=0xFFFFFFFF, b=16 -> 0x0FFFFFFF.
//   3. DIV a=5, b=0 -> 0xFFFFFFFF.
//      REMU a=5, b=0 -> 5.
//      DIV a=0x80000000, b=-1 -> 0x80000000.
//      REM of the same operands -> 0 with zero=1.
//      All four reach out_valid after 1 edge.
//   4. Backpressure: hold out_ready=0 for 10 cycles after out_valid ->
//      result stable and in_ready=0.
//      Then raise out_ready with in_valid high for MULHU a=b=0xFFFFFFFF ->
//      new request accepted on the same edge; result 0xFFFFFFFE.
//   5. Flush in CALC at iteration 10 -> IDLE next edge, out_valid never
//      asserts.
//      flush together with in_valid in IDLE -> no accept.
//   6. rst_n low mid-CALC -> IDLE, out_valid=0, busy=0.
//      Then MULHSU a=-1, b=2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Iterative RV32M multiply/divide unit living beside the single-cycle ALU
//   in EX. A request (op, a, b) is taken through a valid/ready handshake.
//   A radix-2 shift-add multiplier or a restoring divider then runs for
//   WIDTH iterations. The result is held until the consumer takes it.
//   A pipeline flush kills any in-flight or held operation.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   flush      in   1      kill in-flight or held operation
//   in_valid   in   1      request valid
//   in_ready   out  1      request can be accepted this cycle
//   op         in   3      000 MUL 001 MULH 010 MULHSU 011 MULHU
//                          100 DIV 101 DIVU 110 REM 111 REMU
//   a, b       in   WIDTH  operands (rs1, rs2)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  selected result
//   zero       out  1      result == 0
//   busy       out  1      unit not idle
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic en);
        cond_neg_w = en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic en);
        cond_neg_2w = en ? -v : v;
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt_p0;
    logic [2:0]         op_p0;
    logic               neg_q_p0;   // negate product / quotient
    logic               neg_r_p0;   // negate remainder (sign of a)
    logic [WIDTH-1:0]   opnd_p0;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_p0;     // product; low half doubles as dividend/quotient
    logic [WIDTH-1:0]   rem_p0;
    logic [WIDTH-1:0]   res_p1;
    logic               zero_p1;

    // ---------------- request decode ----------------
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]        a_mag, b_mag;
    logic                    div_by_zero, div_ovf, special;
    logic [WIDTH-1:0]        special_res;
    logic                    accept;

    assign a_s    = a;
    assign b_s    = b;
    assign is_div = op[2];
    // Divides are signed when op[0]==0; MULH signs both, MULHSU signs a only.
    assign a_sgn  = is_div ? ~op[0] : ((op == OP_MULH) | (op == OP_MULHSU));
    assign b_sgn  = is_div ? ~op[0] : (op == OP_MULH);
    assign a_neg  = a_sgn & (a_s < $signed(WIDTH'(0)));
    assign b_neg  = b_sgn & (b_s < $signed(WIDTH'(0)));
    assign a_mag  = cond_neg_w(a, a_neg);
    assign b_mag  = cond_neg_w(b, b_neg);

    assign div_by_zero = is_div & (b == '0);
    assign div_ovf     = is_div & ~op[0] & (a == MIN_NEG) & (b == '1);
    assign special     = div_by_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = op[1] ? a : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : a;
        end
    end

    assign in_ready = ((state == S_IDLE) | ((state == S_DONE) & out_ready)) & ~flush;
    assign accept   = in_valid & in_ready;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;   // partial remainder widened for the trial subtract
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;

    assign mul_sum  = {1'b0, acc_p0[2*WIDTH-1:WIDTH]}
                    + (acc_p0[0] ? {1'b0, opnd_p0} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_p0[WIDTH-1:1]};

    assign rem_shift = {rem_p0, acc_p0[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_p0};
    // Borrow out of the trial subtract means restore the shifted value.
    assign rem_next  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    assign quo_next  = {acc_p0[WIDTH-2:0], ~rem_diff[WIDTH]};

    assign acc_next  = op_p0[2] ? {acc_p0[2*WIDTH-1:WIDTH], quo_next} : mul_next;
    assign last_iter = (cnt_p0 == CNT_W'(WIDTH-1));

    // ---------------- sign fixup / result select ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mul_res, quo_fix, rem_fix, div_res, calc_res;

    assign prod_fix = cond_neg_2w(mul_next, neg_q_p0);
    assign mul_res  = (op_p0[1:0] == OP_MUL[1:0]) ? prod_fix[WIDTH-1:0]
                                                  : prod_fix[2*WIDTH-1:WIDTH];
    assign quo_fix  = cond_neg_w(quo_next, neg_q_p0);
    assign rem_fix  = cond_neg_w(rem_next, neg_r_p0);
    assign div_res  = op_p0[1] ? rem_fix : quo_fix;
    assign calc_res = op_p0[2] ? div_res : mul_res;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt_p0 <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
        end else if (accept) begin
            state  <= special ? S_DONE : S_CALC;
            cnt_p0 <= '0;
        end else begin
            case (state)
                S_CALC: begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                    if (last_iter) state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- operand / iteration registers (p0) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= op;
            neg_q_p0 <= a_neg ^ b_neg;
            neg_r_p0 <= a_neg;
            opnd_p0  <= is_div ? b_mag : a_mag;
            acc_p0   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            rem_p0   <= '0;
        end else if (state == S_CALC) begin
            acc_p0   <= acc_next;
            rem_p0   <= rem_next;
        end
    end

    // ---------------- result register (p1) ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (accept && special) begin
            res_p1  <= special_res;
            zero_p1 <= (special_res == '0);
        end else if ((state == S_CALC) && last_iter && !flush) begin
            res_p1  <= calc_res;
            zero_p1 <= (calc_res == '0);
        end
    end

    assign result    = res_p1;
    assign zero      = zero_p1;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule
